// File: rtl/sdcard_img_loader.sv
// Boot-time loader: copies IMG_NUM images from consecutive SD sector ranges into SDRAM slots.
// Optional per-sector RECV watchdog enabled by defining SDCARD_LOADER_TIMEOUT_EN.
module sdcard_img_loader #(
    parameter int unsigned IMG_NUM        = 8,
    parameter int unsigned SECT_PER_IMG   = 3072,
    parameter int unsigned WORDS_PER_SECT = 256,
    parameter int unsigned IMG_WORDS      = 786432,
    parameter int unsigned SD_BASE_SECT   = 16640,
    parameter int unsigned TIMEOUT_CYC    = 1000000
) (
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    input  logic        start,
    input  logic        sd_init_done,
    output logic        sd_rd_req,
    output logic [31:0] sd_rd_addr,
    input  logic        sd_rd_ack,
    input  logic        sd_rd_data_en,
    input  logic [15:0] sd_rd_data,
    output logic        sdram_wr_rst_n,
    output logic [22:0] sdram_wr_b_addr,
    output logic [22:0] sdram_wr_e_addr,
    output logic        sdram_wr_en,
    output logic [15:0] sdram_wr_data,
    output logic [2:0]  img_idx,
    output logic        all_photo_en,
    output logic        load_err
);
    localparam int unsigned AW   = 23;
    localparam int unsigned WC_W = $clog2(WORDS_PER_SECT + 1);
    localparam int unsigned SC_W = $clog2(SECT_PER_IMG + 1);

    typedef enum logic [2:0] {
        IDLE, WAIT_INIT, SET_IMG, REQ, RECV, NEXT, DONE, ERR
    } state_t;

    state_t            state;
    logic [WC_W-1:0]   word_cnt;
    logic [SC_W-1:0]   sect_cnt;
    logic [31:0]       req_addr;
    logic              last_word;
    logic              wd_fire;

    function automatic logic [AW-1:0] slot_base(input logic [2:0] idx);
        return AW'(32'(idx) * IMG_WORDS);
    endfunction

    // Sector address for the current image/sector position.
    assign req_addr  = SD_BASE_SECT + 32'(img_idx) * SECT_PER_IMG + 32'(sect_cnt);
    assign last_word = (word_cnt == WC_W'(WORDS_PER_SECT - 1));

`ifdef SDCARD_LOADER_TIMEOUT_EN
    logic [23:0] wd_cnt;

    // Counts idle cycles in RECV; any returned word restarts the count.
    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            wd_cnt <= '0;
        end else if (state != RECV || sd_rd_data_en) begin
            wd_cnt <= '0;
        end else begin
            wd_cnt <= wd_cnt + 24'd1;
        end
    end

    assign wd_fire = (state == RECV) && !sd_rd_data_en && (wd_cnt == 24'(TIMEOUT_CYC - 1));
`else
    logic unused_timeout;

    assign wd_fire        = 1'b0;
    assign unused_timeout = ^TIMEOUT_CYC;
`endif

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            state           <= IDLE;
            word_cnt        <= '0;
            sect_cnt        <= '0;
            sd_rd_req       <= 1'b0;
            sd_rd_addr      <= '0;
            sdram_wr_rst_n  <= 1'b1;
            sdram_wr_b_addr <= '0;
            sdram_wr_e_addr <= AW'(IMG_WORDS - 1);
            sdram_wr_en     <= 1'b0;
            sdram_wr_data   <= '0;
            img_idx         <= '0;
            all_photo_en    <= 1'b0;
            load_err        <= 1'b0;
        end else begin
            sdram_wr_en    <= 1'b0;
            sdram_wr_rst_n <= 1'b1;
            case (state)
                IDLE: begin
                    if (start) state <= WAIT_INIT;
                end
                WAIT_INIT: begin
                    if (sd_init_done) begin
                        sect_cnt        <= '0;
                        sdram_wr_b_addr <= slot_base(img_idx);
                        sdram_wr_e_addr <= slot_base(img_idx) + AW'(IMG_WORDS - 1);
                        sdram_wr_rst_n  <= 1'b0;
                        state           <= SET_IMG;
                    end
                end
                SET_IMG: begin
                    sd_rd_req  <= 1'b1;
                    sd_rd_addr <= req_addr;
                    state      <= REQ;
                end
                REQ: begin
                    // A word arriving with the ack is the first word of the sector.
                    if (sd_rd_ack) begin
                        sd_rd_req <= 1'b0;
                        word_cnt  <= '0;
                        state     <= RECV;
                        if (sd_rd_data_en) begin
                            sdram_wr_en   <= 1'b1;
                            sdram_wr_data <= sd_rd_data;
                            word_cnt      <= WC_W'(1);
                            if (WORDS_PER_SECT == 1) state <= NEXT;
                        end
                    end
                end
                RECV: begin
                    if (sd_rd_data_en) begin
                        sdram_wr_en   <= 1'b1;
                        sdram_wr_data <= sd_rd_data;
                        word_cnt      <= word_cnt + WC_W'(1);
                        if (last_word) state <= NEXT;
                    end else if (wd_fire) begin
                        load_err <= 1'b1;
                        state    <= ERR;
                    end
                end
                NEXT: begin
                    if (sect_cnt == SC_W'(SECT_PER_IMG - 1)) begin
                        if (img_idx == 3'(IMG_NUM - 1)) begin
                            all_photo_en <= 1'b1;
                            state        <= DONE;
                        end else begin
                            img_idx         <= img_idx + 3'd1;
                            sect_cnt        <= '0;
                            sdram_wr_b_addr <= slot_base(img_idx + 3'd1);
                            sdram_wr_e_addr <= slot_base(img_idx + 3'd1) + AW'(IMG_WORDS - 1);
                            sdram_wr_rst_n  <= 1'b0;
                            state           <= SET_IMG;
                        end
                    end else begin
                        sect_cnt   <= sect_cnt + SC_W'(1);
                        sd_rd_req  <= 1'b1;
                        sd_rd_addr <= req_addr + 32'd1;
                        state      <= REQ;
                    end
                end
                DONE: begin
                    all_photo_en <= 1'b1;
                end
                ERR: begin
                    load_err  <= 1'b1;
                    sd_rd_req <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sdcard_img_loader.sv
// Bench for sdcard_img_loader: table of load scenarios with a randomized SD reader and a
// queue-based reference of expected sector addresses, slot windows and SDRAM writes.
module tb_sdcard_img_loader;
    localparam int unsigned IMG_NUM = 2;
    localparam int unsigned SECT    = 2;
    localparam int unsigned WPS     = 4;
    localparam int unsigned IMGW    = 8;
    localparam int unsigned BASE    = 100;
    localparam int unsigned TO      = 20;

    logic        sys_clk = 1'b0;
    logic        sys_rst_n = 1'b0;
    logic        start = 1'b0;
    logic        sd_init_done = 1'b0;
    logic        sd_rd_req;
    logic [31:0] sd_rd_addr;
    logic        sd_rd_ack = 1'b0;
    logic        sd_rd_data_en = 1'b0;
    logic [15:0] sd_rd_data = '0;
    logic        sdram_wr_rst_n;
    logic [22:0] sdram_wr_b_addr;
    logic [22:0] sdram_wr_e_addr;
    logic        sdram_wr_en;
    logic [15:0] sdram_wr_data;
    logic [2:0]  img_idx;
    logic        all_photo_en;
    logic        load_err;

    sdcard_img_loader #(
        .IMG_NUM(IMG_NUM), .SECT_PER_IMG(SECT), .WORDS_PER_SECT(WPS),
        .IMG_WORDS(IMGW), .SD_BASE_SECT(BASE), .TIMEOUT_CYC(TO)
    ) dut (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .start(start), .sd_init_done(sd_init_done),
        .sd_rd_req(sd_rd_req), .sd_rd_addr(sd_rd_addr), .sd_rd_ack(sd_rd_ack),
        .sd_rd_data_en(sd_rd_data_en), .sd_rd_data(sd_rd_data),
        .sdram_wr_rst_n(sdram_wr_rst_n), .sdram_wr_b_addr(sdram_wr_b_addr),
        .sdram_wr_e_addr(sdram_wr_e_addr), .sdram_wr_en(sdram_wr_en),
        .sdram_wr_data(sdram_wr_data), .img_idx(img_idx), .all_photo_en(all_photo_en),
        .load_err(load_err)
    );

    always #5 sys_clk = ~sys_clk;

    typedef struct {
        int init_delay;
        int ack_max;
        int gap_max;
        bit ack_data;
        bit stray;
        bit seq;
        int exp_writes;
        int exp_reqs;
        bit exp_done;
    } vec_t;

    vec_t        vecs[5];
    int          errors = 0;
    int          checks = 0;
    logic [15:0] exp_q[64];
    int          wr_ptr = 0;
    int          rd_ptr = 0;
    int          wr_count = 0;
    int          req_count = 0;
    int          rst_pulses = 0;
    bit          prev_req = 1'b0;
    bit          prev_rst_low = 1'b0;
    logic [15:0] seq_word = '0;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endfunction

    // Observes the DUT every falling edge against the reference sequence.
    task automatic monitor();
        forever begin
            @(negedge sys_clk);
            if (!sys_rst_n) begin
                rd_ptr = 0; wr_count = 0; req_count = 0; rst_pulses = 0;
                prev_req = 1'b0; prev_rst_low = 1'b0;
            end else begin
                if (sdram_wr_en) begin
                    if (rd_ptr < wr_ptr) begin
                        chk("wr_data", 32'(sdram_wr_data), 32'(exp_q[rd_ptr % 64]));
                    end else begin
                        checks++; errors++;
                        $display("FAIL unexpected_write: got data 0x%0h with no word outstanding", sdram_wr_data);
                    end
                    rd_ptr++; wr_count++;
                end
                if (!sdram_wr_rst_n) begin
                    chk("wr_rst_single_cycle", 32'(prev_rst_low), 32'd0);
                    chk("slot_b_addr", 32'(sdram_wr_b_addr), 32'(rst_pulses) * IMGW);
                    chk("slot_e_addr", 32'(sdram_wr_e_addr), 32'(rst_pulses) * IMGW + IMGW - 1);
                    chk("slot_img_idx", 32'(img_idx), 32'(rst_pulses));
                    rst_pulses++;
                end
                if (sd_rd_req && !prev_req) begin
                    chk("rd_addr", sd_rd_addr, BASE + 32'(req_count));
                    req_count++;
                end
                prev_req     = sd_rd_req;
                prev_rst_low = !sdram_wr_rst_n;
            end
        end
    endtask

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic apply_reset();
        sys_rst_n = 1'b0; start = 1'b0; sd_init_done = 1'b0;
        sd_rd_ack = 1'b0; sd_rd_data_en = 1'b0;
        wr_ptr = 0; seq_word = '0;
        tick(); tick();
        sys_rst_n = 1'b1;
    endtask

    task automatic check_reset_vals();
        chk("rst_sd_rd_req", 32'(sd_rd_req), 32'd0);
        chk("rst_sd_rd_addr", sd_rd_addr, 32'd0);
        chk("rst_wr_rst_n", 32'(sdram_wr_rst_n), 32'd1);
        chk("rst_wr_en", 32'(sdram_wr_en), 32'd0);
        chk("rst_wr_data", 32'(sdram_wr_data), 32'd0);
        chk("rst_b_addr", 32'(sdram_wr_b_addr), 32'd0);
        chk("rst_e_addr", 32'(sdram_wr_e_addr), IMGW - 1);
        chk("rst_img_idx", 32'(img_idx), 32'd0);
        chk("rst_all_photo_en", 32'(all_photo_en), 32'd0);
        chk("rst_load_err", 32'(load_err), 32'd0);
    endtask

    task automatic wait_req(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if (sd_rd_req) begin
                ok = 1'b1;
                return;
            end
            tick();
        end
        checks++; errors++;
        $display("FAIL wait_req: got no sd_rd_req within 300 cycles, required a request");
    endtask

    // Drives one accepted word and records it as an expected SDRAM write.
    task automatic send_word(input bit seq);
        sd_rd_data_en = 1'b1;
        if (seq) begin
            seq_word   = seq_word + 16'd1;
            sd_rd_data = seq_word;
        end else begin
            sd_rd_data = 16'($urandom());
        end
        exp_q[wr_ptr % 64] = sd_rd_data;
        wr_ptr++;
    endtask

    task automatic serve_sector(input vec_t v);
        bit ok;
        int lat;
        int gap;
        int n;
        wait_req(ok);
        if (!ok) return;
        lat = v.seq ? 3 : int'($urandom_range(32'(v.ack_max), 0));
        for (int i = 0; i < lat; i++) begin
            if (v.stray && $urandom_range(1, 0) == 1) begin
                sd_rd_data_en = 1'b1;
                sd_rd_data    = 16'($urandom());
            end
            tick();
            sd_rd_data_en = 1'b0;
        end
        sd_rd_ack = 1'b1;
        n = 0;
        if (v.ack_data) begin
            send_word(v.seq);
            n = 1;
        end
        tick();
        sd_rd_ack = 1'b0; sd_rd_data_en = 1'b0;
        while (n < int'(WPS)) begin
            gap = v.seq ? 0 : int'($urandom_range(32'(v.gap_max), 0));
            repeat (gap) tick();
            send_word(v.seq);
            tick();
            sd_rd_data_en = 1'b0;
            n++;
        end
    endtask

    task automatic load_body(input vec_t v);
        int hi;
        hi = 0;
        if (v.stray) begin
            for (int i = 0; i < 3; i++) begin
                sd_rd_data_en = 1'b1;
                sd_rd_data    = 16'($urandom());
                tick();
                sd_rd_data_en = 1'b0;
            end
            tick(); tick();
            chk("idle_stray_writes", 32'(wr_count), 32'd0);
        end
        start = 1'b1;
        tick();
        start = 1'b0;
        sd_init_done = (v.init_delay == 0);
        for (int i = 0; i < v.init_delay; i++) begin
            if (sd_rd_req) hi++;
            tick();
        end
        if (v.init_delay > 0) chk("req_before_init", 32'(hi), 32'd0);
        sd_init_done = 1'b1;
        for (int s = 0; s < int'(IMG_NUM * SECT); s++) serve_sector(v);
        for (int i = 0; i < 100 && !all_photo_en; i++) tick();
        tick(); tick();
        chk("all_photo_en", 32'(all_photo_en), 32'(v.exp_done));
        chk("write_count", 32'(wr_count), 32'(v.exp_writes));
        chk("request_count", 32'(req_count), 32'(v.exp_reqs));
        chk("slot_reloads", 32'(rst_pulses), IMG_NUM);
        chk("writes_drained", 32'(rd_ptr), 32'(wr_ptr));
        chk("load_err_clear", 32'(load_err), 32'd0);
        chk("img_idx_final", 32'(img_idx), IMG_NUM - 1);
        chk("req_idle_at_end", 32'(sd_rd_req), 32'd0);
        if (v.seq) chk("last_word_data", 32'(sdram_wr_data), 32'h10);
    endtask

    initial begin
        bit ok;
        int n;
        // init_delay, ack_max, gap_max, ack_data, stray, seq, exp_writes, exp_reqs, exp_done
        vecs[0] = '{0,  3, 0, 1'b0, 1'b0, 1'b1, 16, 4, 1'b1};
        vecs[1] = '{5,  5, 3, 1'b0, 1'b0, 1'b0, 16, 4, 1'b1};
        vecs[2] = '{0,  2, 2, 1'b1, 1'b0, 1'b0, 16, 4, 1'b1};
        vecs[3] = '{2,  6, 1, 1'b0, 1'b1, 1'b0, 16, 4, 1'b1};
        vecs[4] = '{50, 4, 4, 1'b1, 1'b1, 1'b0, 16, 4, 1'b1};

        fork
            monitor();
        join_none

        apply_reset();
        check_reset_vals();

        for (int t = 0; t < 5; t++) begin
            apply_reset();
            load_body(vecs[t]);
        end

        // Reset in the middle of image 1 RECV, then a fresh load from sector 100.
        apply_reset();
        start = 1'b1; tick(); start = 1'b0;
        sd_init_done = 1'b1;
        for (int s = 0; s < int'(SECT); s++) serve_sector(vecs[0]);
        wait_req(ok);
        tick(); tick();
        sd_rd_ack = 1'b1; tick(); sd_rd_ack = 1'b0;
        for (int i = 0; i < 2; i++) begin
            send_word(1'b0); tick(); sd_rd_data_en = 1'b0;
        end
        chk("mid_img_idx", 32'(img_idx), 32'd1);
        sys_rst_n = 1'b0; wr_ptr = 0; seq_word = '0;
        tick();
        sys_rst_n = 1'b1;
        check_reset_vals();
        load_body(vecs[0]);

`ifdef SDCARD_LOADER_TIMEOUT_EN
        // Reader stops after two words: watchdog must fire TO cycles after the last one.
        apply_reset();
        start = 1'b1; tick(); start = 1'b0;
        sd_init_done = 1'b1;
        wait_req(ok);
        tick();
        sd_rd_ack = 1'b1; tick(); sd_rd_ack = 1'b0;
        send_word(1'b0); tick(); sd_rd_data_en = 1'b0;
        send_word(1'b0); tick(); sd_rd_data_en = 1'b0;
        n = 0;
        while (n < 40 && !load_err) begin
            tick();
            n++;
        end
        chk("wd_latency", 32'(n), TO);
        chk("wd_load_err", 32'(load_err), 32'd1);
        chk("wd_rd_req", 32'(sd_rd_req), 32'd0);
        chk("wd_all_photo_en", 32'(all_photo_en), 32'd0);
        repeat (3) tick();
        chk("wd_load_err_sticky", 32'(load_err), 32'd1);
        chk("wd_writes", 32'(wr_count), 32'd2);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
